// File: rtl/scanline_fx_if.sv
// Scanline effect bus: scandoubler-side video in, processed video out.
interface scanline_fx_if #(
  parameter int DW = 8
);
  logic          ce_pix;
  logic          hs_in, vs_in, hb_in, vb_in;
  logic [DW-1:0] r_in, g_in, b_in;
  logic [1:0]    mode;
  logic          phase;
  logic          blank_black;
  logic          ce_pix_out;
  logic          hs_out, vs_out, hb_out, vb_out;
  logic [DW-1:0] r_out, g_out, b_out;
  logic          line_odd;

  // Block side
  modport slave (
    input  ce_pix, hs_in, vs_in, hb_in, vb_in, r_in, g_in, b_in,
           mode, phase, blank_black,
    output ce_pix_out, hs_out, vs_out, hb_out, vb_out, r_out, g_out, b_out,
           line_odd
  );

  // Source / sink side
  modport master (
    output ce_pix, hs_in, vs_in, hb_in, vb_in, r_in, g_in, b_in,
           mode, phase, blank_black,
    input  ce_pix_out, hs_out, vs_out, hb_out, vb_out, r_out, g_out, b_out,
           line_odd
  );
endinterface

// File: rtl/scanline_fx.sv
// Scanline dimming on scandoubled video: alternate lines are attenuated by a
// frame-latched strength, with optional forced black during blanking.

// Per-channel pixel path: blank > dim > pass-through.
module scanline_fx_lane #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] x_i,
  input  logic [1:0]    mode_i,
  input  logic          dim_i,
  input  logic          blank_i,
  output logic [DW-1:0] y_o
);
  // Pick output value for this channel
  always_comb begin
    y_o = x_i;
    if (blank_i) begin
      y_o = '0;
    end else if (dim_i) begin
      case (mode_i)
        2'd1:    y_o = x_i - (x_i >> 2);
        2'd2:    y_o = x_i >> 1;
        2'd3:    y_o = x_i >> 2;
        default: y_o = x_i;
      endcase
    end
  end
endmodule

module scanline_fx #(
  parameter int DW = 8
) (
  input  logic          clk_vid,
  input  logic          reset_n,
  scanline_fx_if.slave  bus
);
  localparam int NUM_LANES = 3;

  // Previous-cycle syncs for edge detection, sampled every clock.
  logic hs_prev_q, vs_prev_q;
  logic line_odd_q, line_odd_d;
  logic [1:0] mode_q, mode_d;
  logic hs_rise, vs_rise, dim_en, blank_en;

  logic [NUM_LANES-1:0][DW-1:0] pix_in, pix_d, pix_q;
  logic ce_q, hs_q, vs_q, hb_q, vb_q;

  assign pix_in = {bus.r_in, bus.g_in, bus.b_in};

  genvar l;
  generate
    for (l = 0; l < NUM_LANES; l++) begin : g_lane
      scanline_fx_lane #(.DW(DW)) u_lane (
        .x_i    (pix_in[l]),
        .mode_i (mode_q),
        .dim_i  (dim_en),
        .blank_i(blank_en),
        .y_o    (pix_d[l])
      );
    end
  endgenerate

  // Edge detect, line parity and frame-latched strength
  always_comb begin
    hs_rise    = bus.hs_in & ~hs_prev_q;
    vs_rise    = bus.vs_in & ~vs_prev_q;
    line_odd_d = line_odd_q;
    if (vs_rise)      line_odd_d = 1'b0;   // frame start beats a coincident hs
    else if (hs_rise) line_odd_d = ~line_odd_q;
    mode_d     = vs_rise ? bus.mode : mode_q;
    dim_en     = (mode_q != 2'd0) && (line_odd_q ^ bus.phase);
    blank_en   = bus.blank_black & (bus.hb_in | bus.vb_in);
  end

  // Free-running control state
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      hs_prev_q  <= 1'b0;
      vs_prev_q  <= 1'b0;
      line_odd_q <= 1'b0;
      mode_q     <= 2'd0;
      ce_q       <= 1'b0;
    end else begin
      hs_prev_q  <= bus.hs_in;
      vs_prev_q  <= bus.vs_in;
      line_odd_q <= line_odd_d;
      mode_q     <= mode_d;
      ce_q       <= bus.ce_pix;
    end
  end

  // Video outputs advance only on pixel enable
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      pix_q <= '0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      hb_q  <= 1'b0;
      vb_q  <= 1'b0;
    end else if (bus.ce_pix) begin
      pix_q <= pix_d;
      hs_q  <= bus.hs_in;
      vs_q  <= bus.vs_in;
      hb_q  <= bus.hb_in;
      vb_q  <= bus.vb_in;
    end
  end

  assign bus.ce_pix_out = ce_q;
  assign bus.hs_out     = hs_q;
  assign bus.vs_out     = vs_q;
  assign bus.hb_out     = hb_q;
  assign bus.vb_out     = vb_q;
  assign bus.r_out      = pix_q[2];
  assign bus.g_out      = pix_q[1];
  assign bus.b_out      = pix_q[0];
  assign bus.line_odd   = line_odd_q;
endmodule

// File: tb/tb_scanline_fx.sv
// Bench for scanline_fx: DW=8 and DW=4 instances driven in lockstep, checked
// against a line-counting reference model plus directed value checks.
module tb_scanline_fx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       ce, hs, vs, hb, vb, phase, bb;
  logic [1:0] mode;
  logic [7:0] r, g, b;

  scanline_fx_if #(.DW(8)) bus8 ();
  scanline_fx_if #(.DW(4)) bus4 ();

  assign bus8.ce_pix = ce;  assign bus4.ce_pix = ce;
  assign bus8.hs_in  = hs;  assign bus4.hs_in  = hs;
  assign bus8.vs_in  = vs;  assign bus4.vs_in  = vs;
  assign bus8.hb_in  = hb;  assign bus4.hb_in  = hb;
  assign bus8.vb_in  = vb;  assign bus4.vb_in  = vb;
  assign bus8.mode   = mode; assign bus4.mode  = mode;
  assign bus8.phase  = phase; assign bus4.phase = phase;
  assign bus8.blank_black = bb; assign bus4.blank_black = bb;
  assign bus8.r_in = r; assign bus8.g_in = g; assign bus8.b_in = b;
  assign bus4.r_in = r[7:4]; assign bus4.g_in = g[7:4]; assign bus4.b_in = b[7:4];

  scanline_fx #(.DW(8)) u_dut8 (.clk_vid(clk), .reset_n(rst_n), .bus(bus8));
  scanline_fx #(.DW(4)) u_dut4 (.clk_vid(clk), .reset_n(rst_n), .bus(bus4));

  int checks = 0;
  int failures = 0;

  // Reference model: line number since frame start and the frame's strength
  int m_line, m_mode;
  bit m_hsp, m_vsp;
  bit e_ce, e_hs, e_vs, e_hb, e_vb;
  int e8 [3];
  int e4 [3];

  function automatic int px(int x, int w, bit dim, bit blank, int md);
    int full = (1 << w) - 1;
    if (blank) return 0;
    if (!dim) return x;
    case (md)
      1: return x - x / 4;
      2: return x / 2;
      3: return x / 4;
      default: return x;
    endcase
    return full;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all();
    chk("ce_out8", bus8.ce_pix_out, e_ce); chk("ce_out4", bus4.ce_pix_out, e_ce);
    chk("hs_out", bus8.hs_out, e_hs); chk("vs_out", bus8.vs_out, e_vs);
    chk("hb_out", bus8.hb_out, e_hb); chk("vb_out", bus8.vb_out, e_vb);
    chk("hs_out4", bus4.hs_out, e_hs); chk("vb_out4", bus4.vb_out, e_vb);
    chk("r8", bus8.r_out, e8[0]); chk("g8", bus8.g_out, e8[1]); chk("b8", bus8.b_out, e8[2]);
    chk("r4", bus4.r_out, e4[0]); chk("g4", bus4.g_out, e4[1]); chk("b4", bus4.b_out, e4[2]);
    chk("line_odd8", bus8.line_odd, m_line % 2);
    chk("line_odd4", bus4.line_odd, m_line % 2);
  endtask

  task automatic model_reset();
    m_line = 0; m_mode = 0; m_hsp = 0; m_vsp = 0;
    e_ce = 0; e_hs = 0; e_vs = 0; e_hb = 0; e_vb = 0;
    for (int c = 0; c < 3; c++) begin e8[c] = 0; e4[c] = 0; end
  endtask

  // One clock: predict from pre-edge state, clock, then compare everything
  task automatic tick();
    bit hr, vr, dim, blank;
    int ch [3];
    hr = hs && !m_hsp;
    vr = vs && !m_vsp;
    dim = (m_mode != 0) && (((m_line % 2) == 1) != phase);
    blank = bb && (hb || vb);
    ch[0] = r; ch[1] = g; ch[2] = b;
    if (ce) begin
      e_hs = hs; e_vs = vs; e_hb = hb; e_vb = vb;
      for (int c = 0; c < 3; c++) begin
        e8[c] = px(ch[c], 8, dim, blank, m_mode);
        e4[c] = px(ch[c] / 16, 4, dim, blank, m_mode);
      end
    end
    e_ce = ce;
    if (vr) begin m_line = 0; m_mode = mode; end
    else if (hr) m_line++;
    m_hsp = hs; m_vsp = vs;
    @(posedge clk); #1;
    chk_all();
  endtask

  task automatic pix(int n);
    for (int i = 0; i < n; i++) begin
      ce = 1; tick();
      ce = 0; tick();
    end
  endtask

  task automatic hs_pulse();
    hs = 1; ce = 1; tick();
    hs = 0; ce = 0; tick();
  endtask

  task automatic vs_pulse();
    vs = 1; ce = 1; tick();
    vs = 0; ce = 0; tick();
  endtask

  task automatic set_rgb(logic [7:0] v);
    r = v; g = v; b = v;
  endtask

  initial begin
    ce = 0; hs = 0; vs = 0; hb = 0; vb = 0; phase = 0; bb = 0; mode = 0;
    set_rgb(8'h00);
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk_all();                                   // reset state
    #2 rst_n = 1;

    // 50% on alternate lines
    mode = 2; set_rgb(8'hC8);
    vs_pulse();
    pix(3); chk("l0_c8", bus8.r_out, 8'hC8);
    hs_pulse(); pix(3); chk("l1_64", bus8.r_out, 8'h64);
    hs_pulse(); pix(3); chk("l2_c8", bus8.g_out, 8'hC8);
    hs_pulse(); pix(3); chk("l3_64", bus8.b_out, 8'h64);

    // 25% and 75% at full scale, both widths
    mode = 1; set_rgb(8'hFF);
    vs_pulse(); hs_pulse(); pix(2);
    chk("m1_dw8", bus8.r_out, 8'hC0); chk("m1_dw4", bus4.r_out, 4'hC);
    mode = 3;
    vs_pulse(); hs_pulse(); pix(2);
    chk("m3_dw8", bus8.r_out, 8'h3F); chk("m3_dw4", bus4.r_out, 4'h3);

    // Strength change mid-frame waits for next frame
    mode = 0; vs_pulse(); pix(2);
    mode = 3; hs_pulse(); pix(2);
    chk("midframe_nodim", bus8.r_out, 8'hFF);
    vs_pulse(); pix(2); chk("newframe_l0", bus8.r_out, 8'hFF);
    hs_pulse(); pix(2); chk("newframe_l1", bus8.r_out, 8'h3F);

    // Coincident hs/vs edges: vs wins
    hs_pulse(); chk("pre_coinc_odd", bus8.line_odd, 1'b0);
    hs_pulse(); chk("pre_coinc_odd2", bus8.line_odd, 1'b1);
    hs = 1; vs = 1; ce = 1; tick();
    chk("coinc_odd", bus8.line_odd, 1'b0);
    hs = 0; vs = 0; ce = 0; tick();
    hs_pulse(); chk("after_coinc_odd", bus8.line_odd, 1'b1);

    // Blank forcing and pixel-enable hold
    mode = 0; vs_pulse();
    bb = 1; hb = 1; pix(2); chk("blank_black", bus8.r_out, 8'h00);
    bb = 0; pix(2); chk("blank_pass", bus8.r_out, 8'hFF);
    hb = 0; ce = 0; set_rgb(8'h11);
    repeat (5) tick();
    chk("hold_r", bus8.r_out, 8'hFF); chk("hold_ce_out", bus8.ce_pix_out, 1'b0);

    // Mid-line async reset with ce toggling
    mode = 2; vs_pulse(); hs_pulse(); pix(2);
    ce = 1; set_rgb(8'h77);
    rst_n = 0; model_reset(); #1;
    chk_all(); chk("rst_async_r", bus8.r_out, 8'h00);
    for (int i = 0; i < 4; i++) begin
      ce = ~ce; @(posedge clk); #1; chk_all();
    end
    #2 rst_n = 1;
    set_rgb(8'h5A); ce = 1; tick(); ce = 0;
    chk("post_rst_r", bus8.r_out, 8'h5A);
    hs_pulse(); chk("post_rst_first_hs", bus8.line_odd, 1'b1);
    pix(1); chk("post_rst_nodim", bus8.r_out, 8'h5A);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      ce = $urandom_range(0, 1);
      hs = ($urandom_range(0, 7) == 0);
      vs = ($urandom_range(0, 40) == 0);
      hb = ($urandom_range(0, 5) == 0);
      vb = ($urandom_range(0, 9) == 0);
      bb = $urandom_range(0, 1);
      phase = $urandom_range(0, 1);
      mode = 2'($urandom_range(0, 3));
      r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/scanline_fx.md
SCANLINE_FX -- requirements
Module: scanline_fx

Interface
REQ-001 Parameter DW, default 8: width of each colour channel in bits; legal values 4..8.
REQ-002 Port clk_vid  input  1  video clock; all state changes on its rising edge.
REQ-003 Port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 Port ce_pix  input  1  pixel enable from the scandoubler (ce_pix_out); one clk_vid pulse per output pixel.
REQ-005 Ports hs_in, vs_in, hb_in, vb_in  input  1 each  active-high h-sync, v-sync, h-blank and v-blank from the scandoubler.
REQ-006 Ports r_in, g_in, b_in  input  DW each  pixel colour from the scandoubler.
REQ-007 Port mode  input  2  scanline strength: 0 off, 1 25% dim, 2 50% dim, 3 75% dim.
REQ-008 Port phase  input  1  selects the dimmed line: 0 odd lines, 1 even lines.
REQ-009 Port blank_black  input  1  1 forces RGB to zero while hb_in or vb_in is high.
REQ-010 Port ce_pix_out  output  1  ce_pix delayed by one clk_vid.
REQ-011 Ports hs_out, vs_out, hb_out, vb_out  output  1 each  syncs and blanks aligned to the RGB outputs.
REQ-012 Ports r_out, g_out, b_out  output  DW each  processed colour.
REQ-013 Port line_odd  output  1  current line parity, for debug and verification.

Function
REQ-014 hs_d and vs_d are free-running registers that capture hs_in and vs_in every clk_vid, independent of ce_pix.
- hs rising edge: hs_in=1 and hs_d=0.
- vs rising edge: vs_in=1 and vs_d=0.
REQ-015 line_odd toggles on every hs rising edge.
REQ-016 line_odd is cleared to 0 on every vs rising edge; when both edges occur in the same cycle, the vs rising edge wins and line_odd becomes 0.
REQ-017 A 2-bit mode_q register loads mode only on a vs rising edge, so that a strength change takes effect at frame start; phase and blank_black are used unregistered.
REQ-018 A line is dimmed when mode_q≠0 and line_odd XOR phase = 1, using the line_odd value held before the current clock edge.
REQ-019 Per channel x (DW bits), dim result:
- mode_q=1: x − (x>>2)
- mode_q=2: x>>1
- mode_q=3: x>>2
- all arithmetic is unsigned at DW bits and cannot overflow or underflow.
REQ-020 Output priority:
- blank_black=1 and (hb_in or vb_in)=1: RGB out = 0.
- else line dimmed: RGB out = dim result.
- else: RGB out = input passed through unchanged.
REQ-021 On each clk_vid edge with ce_pix=1, the block registers r/g/b_out, hs_out, vs_out, hb_out and vb_out from the current inputs; latency is exactly 1 clk_vid.
REQ-022 With ce_pix=0, all RGB, sync and blank outputs hold their values; edge detection, line_odd and mode_q still update.
REQ-023 ce_pix_out equals ce_pix registered every clk_vid, so the output data changes on the same cycle that ce_pix_out is high.
REQ-024 The block contains no combinational path from any input to any output.

Reset
REQ-025 While reset_n=0, all of the following are 0: every output, line_odd, mode_q, hs_d and vs_d.
REQ-026 Reset asserted mid-frame forces those values immediately, without waiting for a clock edge.
REQ-027 After reset release, dimming stays off (mode_q=0) until the first vs rising edge loads mode.
REQ-028 After reset release, the first hs rising edge sets line_odd to 1.

Verification
REQ-029 Bench covers: reset_n=0 mid-line with ce_pix toggling -> all outputs 0 at once; after release, r_out=r_in of the previous ce pulse within 1 clk.
REQ-030 Bench covers: mode=2, phase=0, DW=8, r/g/b_in=0xC8 across 4 lines after a vs rising edge -> lines 0 and 2 output 0xC8, lines 1 and 3 output 0x64.
REQ-031 Bench covers: mode=1 then mode=3 with input 0xFF -> dimmed lines output 0xC0 then 0x3F; for DW=4 with input 0xF -> 0xC then 0x3.
REQ-032 Bench covers: mode changes from 0 to 3 mid-frame -> no dimming until the next vs rising edge; dimming applies from the first line after it.
REQ-033 Bench covers: hs and vs rising edges in the same cycle -> line_odd=0, and the next hs rising edge sets it to 1.
REQ-034 Bench covers: blank_black=1, hb_in=1, input 0xFF, mode=0 -> RGB out 0; with blank_black=0 -> 0xFF; ce_pix held low for 5 clk -> outputs unchanged and ce_pix_out=0.
